bf_prog_loader: RTL and testbench
=================================

Name: bf_prog_loader

Overview:
Upstream feeder for the brainhack core's program memory. Accepts a byte stream of ASCII Brainfuck source over a valid/ready handshake and discards non-opcode characters. Translates each opcode character to the 3-bit instruction encoding and writes it sequentially into prgmem. Checks bracket balance and capacity, and releases the core (o_run) only after a clean load.

Parameters:
ADDR_W, 8, program memory address width (matches prgmem_addr_width)
START_ADDR, 1, first prgmem address written; address 0 is never written
DEPTH_W, 6, bracket nesting counter width; maximum depth is 2^DEPTH_W-1

Ports:
clock  input  1  system clock, rising edge
reset_n  input  1  asynchronous, active-low reset
i_start  input  1  single-cycle pulse: abort any activity and begin a new load
i_valid  input  1  i_char is valid
i_char  input  8  ASCII source byte; 0x00 terminates the program
o_ready  output  1  loader accepts a byte this cycle
o_prgmem_we  output  1  prgmem write strobe
o_prgmem_addr  output  ADDR_W  prgmem write address
o_prgmem_data  output  3  instruction to write
o_run  output  1  core may execute; low holds the core idle
o_len  output  ADDR_W  number of instructions written by the last successful load
o_error  output  2  00 ok, 01 unmatched ']', 10 unmatched '[', 11 overflow

Behaviour:
- Reset is asynchronous and active-low. All state clears immediately on assertion.
  - Reset values: state IDLE, o_ready 0, o_prgmem_we 0, o_prgmem_addr 0, o_prgmem_data 0, o_run 0, o_len 0, o_error 00.
- Instruction encoding: '+' 000, '>' 001, '<' 010, '-' 011, '.' 100, ',' 101, '[' 110, ']' 111.
- All other non-zero bytes are comments. They are accepted, not written, and consume no address.
- States:
  - IDLE: o_ready 0. i_start -> LOAD.
  - LOAD: o_ready 1. Byte accepted on a rising edge with i_valid && o_ready.
  - RUN: o_run 1, o_ready 0.
  - ERROR: o_run 0, o_ready 0, o_error held.
- i_start in any state forces LOAD on the next edge and drops o_run that same edge.
  - Clears: write pointer to START_ADDR, depth to 0, count to 0, o_error to 00.
  - o_len keeps its old value until the next successful load.
- Write latency: an opcode byte accepted at edge N produces o_prgmem_we=1 for exactly one cycle after edge N.
  - o_prgmem_addr and o_prgmem_data are registered and valid in that cycle.
  - The pointer then increments.
  - Throughput: one byte per cycle.
- Depth tracking:
  - '[' increments depth.
  - ']' with depth 0 -> ERROR, code 01, and no write occurs.
  - ']' with depth > 0 decrements depth.
  - '[' at maximum depth -> ERROR, code 11, and no write occurs.
- Capacity:
  - Valid addresses are START_ADDR .. 2^ADDR_W-1, so capacity is 2^ADDR_W-START_ADDR instructions.
  - An opcode accepted when the count already equals capacity -> ERROR, code 11, and no write occurs. The pointer never wraps.
- Terminator 0x00 accepted:
  - depth != 0 -> ERROR, code 10.
  - Otherwise -> RUN, with o_len = count, latched on the same edge.
  - An empty program (count 0) is legal: RUN with o_len 0.
- On the transition into ERROR, o_ready drops on the same edge. No further writes occur.
- i_valid while o_ready=0 is ignored. The upstream source must hold the byte until it is accepted.
- i_start and i_valid asserted in the same cycle: i_start wins and the byte is not accepted.

Test Plan:
- Reset then i_start, stream "+[-]",0x00 -> one write per cycle:
  - addr1=000, addr2=110, addr3=011, addr4=111.
  - o_len=4, o_run=1, o_error=00.
- Stream "a+ b>\n",0x00 -> exactly 2 writes: addr1=000, addr2=001. o_len=2.
- Stream "+]" -> one write only, to addr1. ERROR with o_error=01, o_ready=0, o_run=0.
- Stream "[[+]",0x00 -> 4 writes, then o_error=10 and o_run stays 0.
- ADDR_W=3, START_ADDR=1: stream 8 '+' characters -> 7 writes to addr1..7. The 8th gives o_error=11 and no wrap to addr0.
- Assert reset_n low mid-stream -> all outputs go to reset values asynchronously.
  - Then i_start with "+",0x00 -> clean load with o_len=1.

Source files
------------

// File: rtl/bf_prog_loader.sv
// rtl/bf_prog_loader.sv - Brainfuck source loader feeding the core's program memory
//
// Purpose: accepts an ASCII byte stream and drops comment characters. Each opcode
// character is translated to its 3-bit instruction and written sequentially into
// prgmem, starting at START_ADDR. Bracket balance and program capacity are checked,
// and o_run is raised only after a clean, 0x00-terminated load.
//
// Ports:
//   clock, reset_n       rising-edge clock, asynchronous active-low reset
//   i_start              pulse: abort and begin a new load
//   i_valid / i_char     source byte handshake (0x00 terminates the program)
//   o_ready              loader accepts a byte this cycle
//   o_prgmem_we/addr/data  registered prgmem write port
//   o_run                core may execute
//   o_len                instruction count of the last successful load
//   o_error              00 ok, 01 unmatched ']', 10 unmatched '[', 11 overflow

module bf_prog_loader #(
  parameter int ADDR_W     = 8,
  parameter int START_ADDR = 1,
  parameter int DEPTH_W    = 6
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              i_start,
  input  logic              i_valid,
  input  logic [7:0]        i_char,
  output logic              o_ready,
  output logic              o_prgmem_we,
  output logic [ADDR_W-1:0] o_prgmem_addr,
  output logic [2:0]        o_prgmem_data,
  output logic              o_run,
  output logic [ADDR_W-1:0] o_len,
  output logic [1:0]        o_error
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;
  localparam logic [1:0] S_ERROR = 2'd3;

  localparam logic [2:0] OP_OPEN  = 3'b110;
  localparam logic [2:0] OP_CLOSE = 3'b111;

  // count is one bit wider than an address so a full memory is representable
  localparam logic [ADDR_W:0]   CAPACITY  = (ADDR_W+1)'((1 << ADDR_W) - START_ADDR);
  localparam logic [ADDR_W-1:0] ADDR_START = ADDR_W'(START_ADDR);
  localparam logic [ADDR_W-1:0] ADDR_LAST  = '1;
  localparam logic [DEPTH_W-1:0] DEPTH_MAX = '1;

  logic [1:0]         state;
  logic [ADDR_W-1:0]  wr_ptr;
  logic [ADDR_W:0]    count;
  logic [DEPTH_W-1:0] depth;

  logic       is_op;
  logic [2:0] op;
  logic       accept;

  always_comb begin
    is_op = 1'b1;
    op    = 3'b000;
    case (i_char)
      8'h2B:   op = 3'b000; // '+'
      8'h3E:   op = 3'b001; // '>'
      8'h3C:   op = 3'b010; // '<'
      8'h2D:   op = 3'b011; // '-'
      8'h2E:   op = 3'b100; // '.'
      8'h2C:   op = 3'b101; // ','
      8'h5B:   op = 3'b110; // '['
      8'h5D:   op = 3'b111; // ']'
      default: is_op = 1'b0;
    endcase
  end

  assign o_ready = (state == S_LOAD);
  assign o_run   = (state == S_RUN);
  // i_start takes priority: a byte presented in the same cycle is not consumed
  assign accept  = o_ready && i_valid && !i_start;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state         <= S_IDLE;
      wr_ptr        <= '0;
      count         <= '0;
      depth         <= '0;
      o_prgmem_we   <= 1'b0;
      o_prgmem_addr <= '0;
      o_prgmem_data <= 3'b000;
      o_len         <= '0;
      o_error       <= 2'b00;
    end else begin
      o_prgmem_we <= 1'b0;
      if (i_start) begin
        state   <= S_LOAD;
        wr_ptr  <= ADDR_START;
        count   <= '0;
        depth   <= '0;
        o_error <= 2'b00;
      end else if (accept) begin
        if (i_char == 8'h00) begin
          if (depth != '0) begin
            state   <= S_ERROR;
            o_error <= 2'b10;
          end else begin
            state <= S_RUN;
            o_len <= count[ADDR_W-1:0];
          end
        end else if (is_op) begin
          if (op == OP_CLOSE && depth == '0) begin
            state   <= S_ERROR;
            o_error <= 2'b01;
          end else if (op == OP_OPEN && depth == DEPTH_MAX) begin
            state   <= S_ERROR;
            o_error <= 2'b11;
          end else if (count == CAPACITY) begin
            state   <= S_ERROR;
            o_error <= 2'b11;
          end else begin
            o_prgmem_we   <= 1'b1;
            o_prgmem_addr <= wr_ptr;
            o_prgmem_data <= op;
            count         <= count + (ADDR_W+1)'(1);
            // hold at the top address; the capacity check stops any further write
            if (wr_ptr != ADDR_LAST)
              wr_ptr <= wr_ptr + ADDR_W'(1);
            if (op == OP_OPEN)
              depth <= depth + DEPTH_W'(1);
            else if (op == OP_CLOSE)
              depth <= depth - DEPTH_W'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_bf_prog_loader.sv
// tb/tb_bf_prog_loader.sv - self-checking bench for bf_prog_loader
module tb_bf_prog_loader;

  localparam int AW   = 3;
  localparam int SA   = 1;
  localparam int DW   = 2;
  localparam int CAP  = (1 << AW) - SA;
  localparam int DMAX = (1 << DW) - 1;

  logic          clock;
  logic          reset_n;
  logic          i_start;
  logic          i_valid;
  logic [7:0]    i_char;
  logic          o_ready;
  logic          o_prgmem_we;
  logic [AW-1:0] o_prgmem_addr;
  logic [2:0]    o_prgmem_data;
  logic          o_run;
  logic [AW-1:0] o_len;
  logic [1:0]    o_error;

  bf_prog_loader #(.ADDR_W(AW), .START_ADDR(SA), .DEPTH_W(DW)) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .i_start       (i_start),
    .i_valid       (i_valid),
    .i_char        (i_char),
    .o_ready       (o_ready),
    .o_prgmem_we   (o_prgmem_we),
    .o_prgmem_addr (o_prgmem_addr),
    .o_prgmem_data (o_prgmem_data),
    .o_run         (o_run),
    .o_len         (o_len),
    .o_error       (o_error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  byte unsigned stim[$];
  logic [5:0]   cap_q[$];
  logic [5:0]   exp_w[$];
  logic [1:0]   exp_err;
  logic         exp_run;
  int           last_len;
  int           checks;
  int           errors;

  // every prgmem write observed, as {addr, data}
  always @(negedge clock)
    if (reset_n && o_prgmem_we) cap_q.push_back({o_prgmem_addr, o_prgmem_data});

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int code_of(input byte unsigned c);
    string ops;
    ops = "+><-.,[]";
    for (int i = 0; i < 8; i++)
      if (ops[i] == c) return i;
    return -1;
  endfunction

  // reference: walk the source as a list of characters with a running depth
  task automatic model();
    int depth;
    int k;
    exp_w.delete();
    depth   = 0;
    exp_err = 2'b00;
    exp_run = 1'b0;
    foreach (stim[i]) begin
      if (stim[i] == 8'h00) begin
        if (depth != 0) exp_err = 2'b10;
        else begin
          exp_run  = 1'b1;
          last_len = exp_w.size();
        end
        return;
      end
      k = code_of(stim[i]);
      if (k < 0) continue;
      if (k == 7 && depth == 0)    begin exp_err = 2'b01; return; end
      if (k == 6 && depth == DMAX) begin exp_err = 2'b11; return; end
      if (exp_w.size() == CAP)     begin exp_err = 2'b11; return; end
      exp_w.push_back({3'(exp_w.size() + SA), 3'(k)});
      if (k == 6) depth++;
      if (k == 7) depth--;
    end
  endtask

  task automatic load_str(input string s, input bit term);
    stim.delete();
    for (int i = 0; i < s.len(); i++) stim.push_back(s[i]);
    if (term) stim.push_back(8'h00);
  endtask

  task automatic do_start();
    @(negedge clock);
    i_start = 1'b1;
    i_valid = 1'b0;
    @(posedge clock);
    #1 i_start = 1'b0;
    cap_q.delete();
  endtask

  task automatic stream();
    for (int i = 0; i < stim.size(); i++) begin
      @(negedge clock);
      if (!o_ready) break;
      i_char  = stim[i];
      i_valid = 1'b1;
      @(posedge clock);
      #1 i_valid = 1'b0;
    end
    repeat (3) @(negedge clock);
  endtask

  task automatic run_case(input string tag);
    int n;
    model();
    do_start();
    stream();
    chk($sformatf("%s nwr", tag), cap_q.size(), exp_w.size());
    n = (cap_q.size() < exp_w.size()) ? cap_q.size() : exp_w.size();
    for (int i = 0; i < n; i++)
      chk($sformatf("%s wr%0d", tag, i), cap_q[i], exp_w[i]);
    chk($sformatf("%s err", tag), o_error, exp_err);
    chk($sformatf("%s run", tag), o_run, exp_run);
    chk($sformatf("%s ready", tag), o_ready, !(exp_run || exp_err != 2'b00));
    chk($sformatf("%s len", tag), o_len, last_len);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    string pool;
    int    n;
    checks   = 0;
    errors   = 0;
    last_len = 0;
    reset_n  = 1'b0;
    i_start  = 1'b0;
    i_valid  = 1'b0;
    i_char   = 8'h00;
    #1;
    chk("rst ready", o_ready, 0);
    chk("rst we",    o_prgmem_we, 0);
    chk("rst addr",  o_prgmem_addr, 0);
    chk("rst data",  o_prgmem_data, 0);
    chk("rst run",   o_run, 0);
    chk("rst len",   o_len, 0);
    chk("rst err",   o_error, 0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;

    load_str("+[-]", 1);
    run_case("loop");
    chk("loop a1", cap_q.size() > 0 ? cap_q[0] : 6'bx, {3'd1, 3'b000});
    chk("loop a2", cap_q.size() > 1 ? cap_q[1] : 6'bx, {3'd2, 3'b110});
    chk("loop a3", cap_q.size() > 2 ? cap_q[2] : 6'bx, {3'd3, 3'b011});
    chk("loop a4", cap_q.size() > 3 ? cap_q[3] : 6'bx, {3'd4, 3'b111});
    chk("loop len4", o_len, 4);

    load_str("a+ b>\n", 1);
    run_case("comments");
    chk("comments len2", o_len, 2);

    load_str("+]", 0);
    run_case("unmatched_close");
    chk("unmatched_close code", o_error, 2'b01);

    load_str("[[+]", 1);
    run_case("unmatched_open");
    chk("unmatched_open code", o_error, 2'b10);

    load_str("++++++++", 0);
    run_case("capacity");
    chk("capacity code", o_error, 2'b11);

    load_str("[[[[", 1);
    run_case("depth_max");

    // i_start with a byte in the same cycle: byte not consumed, new load begins
    @(negedge clock);
    i_start = 1'b1;
    i_valid = 1'b1;
    i_char  = "+";
    @(posedge clock);
    #1 i_start = 1'b0;
    i_valid = 1'b0;
    @(negedge clock);
    chk("start_wins we", o_prgmem_we, 0);
    chk("start_wins ready", o_ready, 1);
    chk("start_wins run", o_run, 0);
    load_str("", 1);
    model();
    stream();
    chk("empty run", o_run, 1);
    chk("empty len", o_len, 0);

    // asynchronous reset in the middle of a load
    load_str("++-", 1);
    run_case("pre_reset");
    do_start();
    @(negedge clock);
    i_char  = "+";
    i_valid = 1'b1;
    @(posedge clock);
    @(posedge clock);
    #2 reset_n = 1'b0;
    #1;
    chk("async ready", o_ready, 0);
    chk("async we",    o_prgmem_we, 0);
    chk("async addr",  o_prgmem_addr, 0);
    chk("async data",  o_prgmem_data, 0);
    chk("async run",   o_run, 0);
    chk("async len",   o_len, 0);
    chk("async err",   o_error, 0);
    i_valid = 1'b0;
    @(negedge clock);
    reset_n  = 1'b1;
    last_len = 0;
    load_str("+", 1);
    run_case("after_reset");
    chk("after_reset len1", o_len, 1);

    pool = "+><-.,[]a \n[]]";
    for (int t = 0; t < 60; t++) begin
      stim.delete();
      n = $urandom_range(0, 12);
      for (int i = 0; i < n; i++)
        stim.push_back(pool[$urandom_range(0, pool.len() - 1)]);
      stim.push_back(8'h00);
      run_case($sformatf("rnd%0d", t));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
